button_event_decoder: RTL
=========================

// Module: button_event_decoder
// PURPOSE
//  Consumes the clean level from the button debouncer (same clk domain, already registered).
//  Classifies the level into press/release edges, single click, double click and long press.
//  Emits each as a one-cycle strobe for the control logic.
//  Timing runs on an internal millisecond-style tick from a prescaler.
// PARAMETERS
//  TICK_DIV   38000  clk cycles per timer tick (1 ms at 38 MHz)
//  LONG_T     1000   ticks held continuously before long_press fires
//  DCLICK_T   300    ticks after a short release within which a second press makes a double click
//  TW         11     timer width in bits; must satisfy 2^TW > max(LONG_T, DCLICK_T)
// PORTS
//  clk           in   1  system clock, rising edge
//  reset         in   1  asynchronous, active-high; clears all state and outputs immediately
//  en            in   1  decoder enable; low = FSM forced to IDLE, no strobes
//  btn_db        in   1  debounced button level, 1 = pressed
//  held          out  1  registered copy of btn_db (btn_q)
//  press_pulse   out  1  1-cycle strobe on rising edge of btn_db
//  release_pulse out  1  1-cycle strobe on falling edge of btn_db
//  single_click  out  1  1-cycle strobe: short press not followed by second press within DCLICK_T
//  double_click  out  1  1-cycle strobe: two short presses, issued on the second release
//  long_press    out  1  1-cycle strobe: press held LONG_T ticks; issued once per hold
// BEHAVIOUR
//  Reset: all outputs 0, btn_q=0, FSM=IDLE, prescaler=0, timer=0.
//  Edge detection:
//   - btn_q <= btn_db every clk.
//   - rise = btn_db & ~btn_q; fall = ~btn_db & btn_q.
//   - All outputs are registered, so latency is 1 clk from the sampling edge.
//  Edge strobes: press_pulse and release_pulse follow edges regardless of en.
//  Edge at reset release: a button held high across reset release produces one press_pulse.
//   This is intended.
//  Prescaler:
//   - Counts 0..TICK_DIV-1; tick=1 on the wrap cycle.
//   - timer increments on tick and saturates at 2^TW-1.
//   - Prescaler and timer are both cleared on every FSM state change.
//   - Result: timeout N fires exactly N*TICK_DIV clks after entry.
//  FSM states (click strobes only; evaluated only when en=1):
//   - IDLE: on rise -> PRESS1.
//   - PRESS1:
//     - fall before timer==LONG_T -> WAIT2.
//     - timer==LONG_T -> long_press=1, -> LONG.
//   - LONG: on fall -> IDLE. No click strobe.
//   - WAIT2:
//     - rise before timer==DCLICK_T -> PRESS2.
//     - timer==DCLICK_T -> single_click=1, -> IDLE.
//   - PRESS2:
//     - fall -> double_click=1, -> IDLE.
//     - timer==LONG_T -> long_press=1, -> LONG. The double click is discarded.
//  Simultaneous events:
//   - Edge and timeout in the same cycle: the edge wins (the transition is taken, no timeout strobe).
//   - The only exception is at timer==DCLICK_T: a rise counts as a second press.
//  Strobe exclusivity:
//   - At most one of single_click, double_click and long_press is high in any cycle.
//   - Each gesture yields exactly one of them, or none if aborted.
//  en=0: FSM <= IDLE, timer/prescaler cleared, pending click discarded; held and edge strobes still active.
//  Reset mid-gesture: everything clears asynchronously; a pending single/double/long is never emitted.
// TESTING  (TICK_DIV=4, LONG_T=10, DCLICK_T=5, en=1 unless stated)
//  1. Assert reset with btn_db=0 -> all outputs 0; release -> no strobes for 100 clks.
//  2. Short press and wait:
//     - Stimulus: btn_db high 8 clks, then low.
//     - press_pulse 1 clk after rise; release_pulse 1 clk after fall.
//     - single_click exactly 20 clks after WAIT2 entry; no other click strobe.
//  3. Double click:
//     - Stimulus: high 8, low 8, high 8, low.
//     - double_click 1 clk after the second fall; no single_click; two press_pulse, two release_pulse.
//  4. Long press:
//     - Stimulus: hold high 60 clks.
//     - long_press once, 40 clks after PRESS1 entry.
//     - On release only release_pulse; no single_click or double_click.
//  5. Reset in WAIT2: short press, then pulse reset 10 clks after release -> single_click never asserts.
//  6. en low:
//     - Stimulus: en=0 while doing a short press.
//     - held and press_pulse/release_pulse toggle; no click or long strobes.
//     - Raise en mid-hold -> no long_press until a fresh rise.

Source files
------------

// File: rtl/button_event_decoder.sv
// button_event_decoder
//   Classifies a debounced button level into edge strobes and gestures:
//   press/release edges, single click, double click and long press.
//   All strobes are registered and last exactly one clk cycle.
//   Gesture timing uses a prescaled tick (TICK_DIV clks per tick).
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   asynchronous, active-high; clears all state and outputs
//   en            in   decoder enable; low holds the gesture FSM in IDLE
//   btn_db        in   debounced button level, 1 = pressed
//   held          out  registered copy of btn_db
//   press_pulse   out  strobe on a rising edge of btn_db (independent of en)
//   release_pulse out  strobe on a falling edge of btn_db (independent of en)
//   single_click  out  strobe: short press, no second press within DCLICK_T ticks
//   double_click  out  strobe: two short presses, issued on the second release
//   long_press    out  strobe: press held LONG_T ticks, once per hold
module button_event_decoder #(
    parameter int unsigned TICK_DIV = 38000,
    parameter int unsigned LONG_T   = 1000,
    parameter int unsigned DCLICK_T = 300,
    parameter int unsigned TW       = 11
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic btn_db,
    output logic held,
    output logic press_pulse,
    output logic release_pulse,
    output logic single_click,
    output logic double_click,
    output logic long_press
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        LONG,
        WAIT2,
        PRESS2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            btn_q;
    logic            press_q, release_q;
    logic            single_q, single_d;
    logic            double_q, double_d;
    logic            long_q, long_d;

    logic rise, fall, tick, long_hit, dclick_hit;

    always_comb begin
        rise = btn_db & ~btn_q;
        fall = ~btn_db & btn_q;
        tick = (presc_q == PW'(TICK_DIV - 1));
        // Timeouts are detected on the tick that would carry the timer to N,
        // so the registered strobe lands exactly N*TICK_DIV clks after entry.
        long_hit   = tick && (timer_q == TW'(LONG_T - 1));
        dclick_hit = tick && (timer_q == TW'(DCLICK_T - 1));
    end

    // Gesture FSM: edges take priority over timeouts in the same cycle.
    always_comb begin
        state_d  = state_q;
        single_d = 1'b0;
        double_d = 1'b0;
        long_d   = 1'b0;
        if (!en) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (rise) state_d = PRESS1;
                end
                PRESS1: begin
                    if (fall) begin
                        state_d = WAIT2;
                    end else if (long_hit) begin
                        long_d  = 1'b1;
                        state_d = LONG;
                    end
                end
                LONG: begin
                    if (fall) state_d = IDLE;
                end
                WAIT2: begin
                    if (rise) begin
                        state_d = PRESS2;
                    end else if (dclick_hit) begin
                        single_d = 1'b1;
                        state_d  = IDLE;
                    end
                end
                PRESS2: begin
                    if (fall) begin
                        double_d = 1'b1;
                        state_d  = IDLE;
                    end else if (long_hit) begin
                        long_d  = 1'b1;
                        state_d = LONG;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Prescaler and timer restart on every state change and while disabled.
    always_comb begin
        presc_d = presc_q;
        timer_d = timer_q;
        if (!en || (state_d != state_q)) begin
            presc_d = '0;
            timer_d = '0;
        end else if (tick) begin
            presc_d = '0;
            if (timer_q != '1) timer_d = timer_q + 1'b1;
        end else begin
            presc_d = presc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            timer_q   <= '0;
            btn_q     <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            single_q  <= 1'b0;
            double_q  <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            timer_q   <= timer_d;
            btn_q     <= btn_db;
            press_q   <= rise;
            release_q <= fall;
            single_q  <= single_d;
            double_q  <= double_d;
            long_q    <= long_d;
        end
    end

    assign held          = btn_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign single_click  = single_q;
    assign double_click  = double_q;
    assign long_press    = long_q;

endmodule
